// File: rtl/megarom_ram_arbiter.sv
// megarom_ram_arbiter: two-requester arbiter (cartridge bus A, loader B) in front of one RAM port.
// Define MEGAROM_ARB_STARVE_GUARD_EN to let B win after STARVE_LIMIT back-to-back A grants.
module megarom_ram_arbiter #(
  parameter int                  ADDR_WIDTH   = 22,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = '0,
  parameter int                  STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic                  A_REQ,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic                  A_WE,
  input  logic [7:0]            A_WDATA,
  output logic                  A_ACK,
  output logic [7:0]            A_RDATA,
  input  logic                  B_REQ,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic                  B_WE,
  input  logic [7:0]            B_WDATA,
  output logic                  B_ACK,
  output logic [7:0]            B_RDATA,
  output logic                  RAM_REQ,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic                  RAM_WE,
  output logic [7:0]            RAM_WDATA,
  input  logic                  RAM_ACK,
  input  logic [7:0]            RAM_RDATA
);
  typedef enum logic [2:0] {IDLE, BUSY_A, BUSY_B, DONE_A, DONE_B} state_t;
  state_t state, state_n;
  logic a_ign, b_ign, a_req, b_req, grant_b;
  // a request dropped during its own ack cycle is not honoured in the following idle cycle
  assign a_req = A_REQ & ~a_ign;
  assign b_req = B_REQ & ~b_ign;
`ifdef MEGAROM_ARB_STARVE_GUARD_EN
  logic [3:0] starve;
  assign grant_b = b_req & (~a_req | (starve >= 4'(STARVE_LIMIT)));
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) starve <= '0;
    else if (state == IDLE) begin
      if (state_n == BUSY_B || !b_req) starve <= '0;
      else if (state_n == BUSY_A && starve != 4'hF) starve <= starve + 4'd1;
    end
`else
  assign grant_b = b_req & ~a_req;
`endif
  always_comb begin
    state_n = IDLE;
    unique case (state)
      IDLE:    state_n = grant_b ? BUSY_B : a_req ? BUSY_A : IDLE;
      BUSY_A:  state_n = RAM_ACK ? DONE_A : BUSY_A;
      BUSY_B:  state_n = RAM_ACK ? DONE_B : BUSY_B;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      state     <= IDLE;
      RAM_REQ   <= 1'b0;
      RAM_ADDR  <= '0;
      RAM_WE    <= 1'b0;
      RAM_WDATA <= '0;
      A_ACK     <= 1'b0;
      B_ACK     <= 1'b0;
      A_RDATA   <= '0;
      B_RDATA   <= '0;
      a_ign     <= 1'b0;
      b_ign     <= 1'b0;
    end else begin
      state   <= state_n;
      RAM_REQ <= (state_n == BUSY_A) || (state_n == BUSY_B);
      A_ACK   <= state_n == DONE_A;
      B_ACK   <= state_n == DONE_B;
      a_ign   <= (state == DONE_A) && !A_REQ;
      b_ign   <= (state == DONE_B) && !B_REQ;
      if (state == IDLE && state_n == BUSY_A) begin
        RAM_ADDR  <= A_ADDR + RAM_BASE;
        RAM_WE    <= A_WE;
        RAM_WDATA <= A_WDATA;
      end
      if (state == IDLE && state_n == BUSY_B) begin
        RAM_ADDR  <= B_ADDR + RAM_BASE;
        RAM_WE    <= B_WE;
        RAM_WDATA <= B_WDATA;
      end
      if (state == BUSY_A && RAM_ACK) A_RDATA <= RAM_RDATA;
      if (state == BUSY_B && RAM_ACK) B_RDATA <= RAM_RDATA;
    end
endmodule

// File: tb/tb_megarom_ram_arbiter.sv
// tb_megarom_ram_arbiter: randomized self-checking bench against a transaction-level model.
module tb_megarom_ram_arbiter;
  localparam int AW = 22;
  localparam logic [AW-1:0] BASE = 22'h020000;
  localparam int LIM = 4;
`ifdef MEGAROM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic CLK = 1'b0, RESET_n;
  logic A_REQ = 0, A_WE = 0, A_ACK, B_REQ = 0, B_WE = 0, B_ACK;
  logic [AW-1:0] A_ADDR = '0, B_ADDR = '0, RAM_ADDR;
  logic [7:0] A_WDATA = '0, B_WDATA = '0, A_RDATA, B_RDATA, RAM_WDATA, RAM_RDATA = '0;
  logic RAM_REQ, RAM_WE, RAM_ACK = 0;
  int checks = 0, errors = 0;
  logic [7:0] ref_a_rd = '0, ref_b_rd = '0;

  megarom_ram_arbiter #(.ADDR_WIDTH(AW), .RAM_BASE(BASE), .STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RESET_n(RESET_n),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_WE(A_WE), .A_WDATA(A_WDATA), .A_ACK(A_ACK), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_WE(B_WE), .B_WDATA(B_WDATA), .B_ACK(B_ACK), .B_RDATA(B_RDATA),
    .RAM_REQ(RAM_REQ), .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA),
    .RAM_ACK(RAM_ACK), .RAM_RDATA(RAM_RDATA)
  );

  always #5 CLK = ~CLK;

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
    longint s;
    s = longint'(a) + longint'(BASE);
    return AW'(s % (longint'(1) << AW));
  endfunction

  // RAM-side responder: waits for a request, holds off ACK for 'delay' cycles, returns what it saw
  task automatic serve(input int delay, input logic [7:0] rd, output logic got,
                       output logic [AW-1:0] addr, output logic we, output logic [7:0] wd,
                       output logic stable, output logic a_ack, output logic b_ack);
    int n;
    n = 0; got = 0; stable = 1; addr = '0; we = 0; wd = '0; a_ack = 0; b_ack = 0;
    while (!got && n < 20) begin
      @(negedge CLK);
      n++;
      got = RAM_REQ;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout RAM_REQ got 0 want 1 within 20 cycles");
      return;
    end
    addr = RAM_ADDR; we = RAM_WE; wd = RAM_WDATA;
    A_ADDR = AW'($urandom); B_ADDR = AW'($urandom);
    A_WDATA = 8'($urandom); B_WDATA = 8'($urandom);
    A_WE = 1'($urandom); B_WE = 1'($urandom);
    repeat (delay) begin
      @(negedge CLK);
      if (!RAM_REQ || RAM_ADDR !== addr || RAM_WE !== we || RAM_WDATA !== wd || A_ACK || B_ACK) stable = 0;
    end
    RAM_ACK = 1; RAM_RDATA = rd;
    @(negedge CLK);
    RAM_ACK = 0; RAM_RDATA = 8'($urandom);
    a_ack = A_ACK; b_ack = B_ACK;
  endtask

  task automatic test_reset();
    RESET_n = 1;
    #1 RESET_n = 0;
    #1;
    checks++;
    if ({RAM_REQ, RAM_ADDR, RAM_WE, RAM_WDATA, A_ACK, B_ACK, A_RDATA, B_RDATA} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {RAM_REQ, RAM_ADDR, RAM_WE, RAM_WDATA, A_ACK, B_ACK, A_RDATA, B_RDATA});
    end
    repeat (3) @(negedge CLK);
    RESET_n = 1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({RAM_REQ, A_ACK, B_ACK} !== 3'b000) begin
      errors++; $display("FAIL reset_release_idle got %b want 000", {RAM_REQ, A_ACK, B_ACK});
    end
  endtask

  task automatic test_latency();
    A_REQ = 1; A_ADDR = 22'h000100; A_WE = 0;
    @(negedge CLK);
    checks++;
    if (RAM_REQ !== 1'b1) begin errors++; $display("FAIL lat_ram_req got %b want 1", RAM_REQ); end
    checks++;
    if (RAM_ADDR !== 22'h020100) begin errors++; $display("FAIL lat_ram_addr got %h want 020100", RAM_ADDR); end
    RAM_ACK = 1; RAM_RDATA = 8'h5A;
    @(negedge CLK);
    RAM_ACK = 0; A_REQ = 0;
    checks++;
    if ({A_ACK, B_ACK, RAM_REQ} !== 3'b100) begin
      errors++; $display("FAIL lat_ack got %b want 100", {A_ACK, B_ACK, RAM_REQ});
    end
    checks++;
    if (A_RDATA !== 8'h5A) begin errors++; $display("FAIL lat_rdata got %h want 5a", A_RDATA); end
    ref_a_rd = 8'h5A;
    @(negedge CLK);
    checks++;
    if (A_ACK !== 1'b0 || A_RDATA !== 8'h5A) begin
      errors++; $display("FAIL lat_ack_one_cycle got ack %b rdata %h want 0 5a", A_ACK, A_RDATA);
    end
  endtask

  task automatic test_wrap();
    logic got, we, st, aa, ba;
    logic [AW-1:0] addr;
    logic [7:0] wd;
    A_REQ = 1; A_ADDR = 22'h3FFFFF; A_WE = 0;
    serve(1, 8'h17, got, addr, we, wd, st, aa, ba);
    A_REQ = 0;
    ref_a_rd = 8'h17;
    checks++;
    if (addr !== 22'h01FFFF) begin errors++; $display("FAIL wrap_addr got %h want 01ffff", addr); end
    checks++;
    if (aa !== 1'b1 || A_RDATA !== 8'h17) begin
      errors++; $display("FAIL wrap_ack got ack %b rdata %h want 1 17", aa, A_RDATA);
    end
    @(negedge CLK);
  endtask

  task automatic test_write_delay();
    logic got, we, st, aa, ba;
    logic [AW-1:0] addr, sb;
    logic [7:0] wd;
    int acks;
    sb = AW'($urandom);
    B_REQ = 1; B_ADDR = sb; B_WE = 1; B_WDATA = 8'hC3;
    serve(5, 8'h96, got, addr, we, wd, st, aa, ba);
    B_REQ = 0;
    ref_b_rd = 8'h96;
    checks++;
    if (addr !== exp_addr(sb) || we !== 1'b1 || wd !== 8'hC3) begin
      errors++; $display("FAIL wr_fields got %h %b %h want %h 1 c3", addr, we, wd, exp_addr(sb));
    end
    checks++;
    if (st !== 1'b1) begin errors++; $display("FAIL wr_stable got %b want 1", st); end
    checks++;
    if ({aa, ba} !== 2'b01) begin errors++; $display("FAIL wr_ack got a%b b%b want a0 b1", aa, ba); end
    checks++;
    if (B_RDATA !== 8'h96 || A_RDATA !== ref_a_rd) begin
      errors++; $display("FAIL wr_rdata got b %h a %h want 96 %h", B_RDATA, A_RDATA, ref_a_rd);
    end
    acks = 0;
    repeat (3) begin
      @(negedge CLK);
      acks += int'(A_ACK) + int'(B_ACK);
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL wr_extra_acks got %0d want 0", acks); end
  endtask

  task automatic test_grant_order();
    logic got, we, st, aa, ba, want_b;
    logic [AW-1:0] addr, sa, sb;
    logic [7:0] wd, rd;
    int run_a;
    run_a = 0;
    A_REQ = 1; B_REQ = 1;
    for (int i = 0; i < 10; i++) begin
      want_b = GUARD && run_a >= LIM;
      run_a = want_b ? 0 : run_a + 1;
      sa = A_ADDR; sb = B_ADDR;
      rd = 8'($urandom);
      serve($urandom_range(0, 2), rd, got, addr, we, wd, st, aa, ba);
      if (want_b) ref_b_rd = rd; else ref_a_rd = rd;
      checks++;
      if ({aa, ba} !== {~want_b, want_b}) begin
        errors++; $display("FAIL grant_order[%0d] got a%b b%b want a%b b%b", i, aa, ba, ~want_b, want_b);
      end
      checks++;
      if (addr !== exp_addr(want_b ? sb : sa) || A_RDATA !== ref_a_rd || B_RDATA !== ref_b_rd) begin
        errors++; $display("FAIL grant_data[%0d] got %h %h %h want %h %h %h", i, addr, A_RDATA, B_RDATA,
                           exp_addr(want_b ? sb : sa), ref_a_rd, ref_b_rd);
      end
    end
    A_REQ = 0; B_REQ = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({RAM_REQ, A_ACK, B_ACK} !== 3'b000) begin
      errors++; $display("FAIL grant_quiet got %b want 000", {RAM_REQ, A_ACK, B_ACK});
    end
  endtask

  task automatic test_random();
    logic got, we, st, aa, ba, who, xwe;
    logic [AW-1:0] addr, xa;
    logic [7:0] wd, xd, rd;
    for (int i = 0; i < 30; i++) begin
      who = 1'($urandom); xa = AW'($urandom); xwe = 1'($urandom); xd = 8'($urandom); rd = 8'($urandom);
      if (who) begin B_REQ = 1; B_ADDR = xa; B_WE = xwe; B_WDATA = xd; end
      else begin A_REQ = 1; A_ADDR = xa; A_WE = xwe; A_WDATA = xd; end
      serve($urandom_range(0, 3), rd, got, addr, we, wd, st, aa, ba);
      A_REQ = 0; B_REQ = 0;
      if (who) ref_b_rd = rd; else ref_a_rd = rd;
      checks++;
      if (addr !== exp_addr(xa) || we !== xwe || wd !== xd || st !== 1'b1) begin
        errors++; $display("FAIL rnd_fields[%0d] got %h %b %h st%b want %h %b %h st1", i, addr, we, wd, st,
                           exp_addr(xa), xwe, xd);
      end
      checks++;
      if ({aa, ba} !== {~who, who}) begin
        errors++; $display("FAIL rnd_ack[%0d] got a%b b%b want a%b b%b", i, aa, ba, ~who, who);
      end
      checks++;
      if (A_RDATA !== ref_a_rd || B_RDATA !== ref_b_rd) begin
        errors++; $display("FAIL rnd_rdata[%0d] got %h %h want %h %h", i, A_RDATA, B_RDATA, ref_a_rd, ref_b_rd);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_stray_idle();
    RAM_ACK = 1; RAM_RDATA = ~ref_a_rd;
    @(negedge CLK);
    RAM_ACK = 0;
    repeat (3) begin
      checks++;
      if ({RAM_REQ, A_ACK, B_ACK} !== 3'b000 || A_RDATA !== ref_a_rd || B_RDATA !== ref_b_rd) begin
        errors++; $display("FAIL stray_idle got %b %h %h want 000 %h %h", {RAM_REQ, A_ACK, B_ACK},
                           A_RDATA, B_RDATA, ref_a_rd, ref_b_rd);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_busy();
    int acks;
    A_REQ = 1; A_ADDR = AW'($urandom); A_WE = 1; A_WDATA = 8'hFF;
    @(negedge CLK);
    checks++;
    if (RAM_REQ !== 1'b1) begin errors++; $display("FAIL rb_busy got %b want 1", RAM_REQ); end
    #2 RESET_n = 0;
    #1;
    checks++;
    if ({RAM_REQ, RAM_ADDR, RAM_WE, RAM_WDATA, A_ACK, B_ACK, A_RDATA, B_RDATA} !== '0) begin
      errors++;
      $display("FAIL rb_async_clear got %h want 0", {RAM_REQ, RAM_ADDR, RAM_WE, RAM_WDATA, A_ACK, B_ACK, A_RDATA, B_RDATA});
    end
    A_REQ = 0;
    ref_a_rd = '0; ref_b_rd = '0;
    @(negedge CLK);
    RESET_n = 1;
    RAM_ACK = 1; RAM_RDATA = 8'hA5;
    acks = 0;
    repeat (4) begin
      @(negedge CLK);
      RAM_ACK = 0;
      acks += int'(A_ACK) + int'(B_ACK) + int'(RAM_REQ);
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL rb_no_ack got %0d want 0", acks); end
    checks++;
    if (A_RDATA !== 8'h00 || B_RDATA !== 8'h00) begin
      errors++; $display("FAIL rb_rdata got %h %h want 00 00", A_RDATA, B_RDATA);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_write_delay();
    test_grant_order();
    test_random();
    test_stray_idle();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/megarom_ram_arbiter.md
MEGAROM_RAM_ARBITER -- requirements
Module: megarom_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 22; width of all address ports.
REQ-002 Parameter RAM_BASE, default 0; offset added to every granted address.
REQ-003 Parameter STARVE_LIMIT, default 4, range 1..15; consecutive A grants allowed while B is pending.
REQ-004 CLK  in  1  single system clock; all logic rising-edge.
REQ-005 RESET_n  in  1  asynchronous active-low reset.
REQ-006 A_REQ  in  1  cartridge-bus request, high-priority requester.
REQ-007 A_ADDR  in  ADDR_WIDTH  A address; A_WE in 1 write flag; A_WDATA in 8 write data.
REQ-008 A_ACK  out  1  one-cycle completion pulse; A_RDATA out 8 read data, valid when A_ACK=1.
REQ-009 B_REQ, B_ADDR, B_WE, B_WDATA, B_ACK, B_RDATA: same as REQ-006..008, loader/config requester.
REQ-010 RAM_REQ  out  1  request to RAM, held until RAM_ACK.
REQ-011 RAM_ADDR  out  ADDR_WIDTH; RAM_WE out 1; RAM_WDATA out 8; all registered, stable while RAM_REQ=1.
REQ-012 RAM_ACK  in  1  RAM completion strobe; RAM_RDATA in 8, valid when RAM_ACK=1.

Function
REQ-013 FSM states IDLE, BUSY_A, BUSY_B, DONE_A, DONE_B; all outputs registered.
REQ-014 IDLE: A_REQ=1 -> BUSY_A; else B_REQ=1 -> BUSY_B; else stay. Exception: REQ-022.
REQ-015 IDLE->BUSY_x edge: latch x_ADDR+RAM_BASE (mod 2^ADDR_WIDTH, wraps, no carry out), x_WE, x_WDATA; set RAM_REQ=1.
REQ-016 BUSY_x: hold RAM_REQ and latched fields; RAM_ACK=1 -> DONE_x, clear RAM_REQ, capture RAM_RDATA into x_RDATA.
REQ-017 DONE_x: x_ACK=1 for exactly this cycle; next state IDLE unconditionally.
REQ-018 x_REQ is ignored in DONE_x and in the IDLE cycle that follows it only if it was sampled low in DONE_x; requester drops x_REQ during the x_ACK cycle.
REQ-019 Minimum latency: x_REQ sampled in IDLE at cycle 0, RAM_REQ high in cycle 1, RAM_ACK in cycle 1 -> x_ACK in cycle 2.
REQ-020 RAM_ACK outside BUSY_x is ignored; no state or data change.
REQ-021 x_RDATA holds its last value between acks; on write transactions x_RDATA is still updated from RAM_RDATA.
REQ-022 Starvation counter (4 bits): increments on each IDLE->BUSY_A with B_REQ=1; clears on IDLE->BUSY_B or in IDLE with B_REQ=0; saturates at 15.
REQ-023 Simultaneous A_REQ and B_REQ in IDLE with counter < STARVE_LIMIT: grant A.
REQ-024 Never more than one RAM transaction outstanding; never both x_ACK high in same cycle.

Reset
REQ-025 RESET_n low: state IDLE, RAM_REQ=0, RAM_ADDR=0, RAM_WE=0, RAM_WDATA=0, A_ACK=B_ACK=0, A_RDATA=B_RDATA=0, counter 0.
REQ-026 Reset during BUSY_x abandons the transaction; no x_ACK issued after release; first cycle after release is IDLE.

Configuration
REQ-027 Macro MEGAROM_ARB_STARVE_GUARD_EN defined: IDLE with A_REQ=B_REQ=1 and counter >= STARVE_LIMIT grants B.
REQ-028 Macro undefined: counter logic absent, strict A priority per REQ-014; B may starve indefinitely.

Verification
REQ-029 Reset, A_REQ=1 A_ADDR=0x00100 A_WE=0, RAM_BASE=0x20000, RAM_ACK in cycle 1 with RAM_RDATA=0x5A -> RAM_ADDR=0x20100, A_ACK and A_RDATA=0x5A in cycle 2.
REQ-030 A_ADDR=0x3FFFFF, RAM_BASE=0x000002, ADDR_WIDTH=22 -> RAM_ADDR=0x000001.
REQ-031 A_REQ and B_REQ both held high (re-asserted after each ack), guard enabled, STARVE_LIMIT=4 -> grant order A,A,A,A,B,A,A,A,A,B; guard disabled -> A only.
REQ-032 B write B_WDATA=0xC3, RAM_ACK delayed 5 cycles -> RAM_REQ/RAM_WE/RAM_WDATA stable 5 cycles, B_ACK once, A_ACK never.
REQ-033 RESET_n pulsed low while BUSY_A -> all outputs 0 immediately; no A_ACK after release; stray RAM_ACK in IDLE ignored.
REQ-034 RAM_ACK pulsed in IDLE with no requests -> no ACK, no state change, RDATA unchanged.
